// File: rtl/chained_zero_detect_pkg.sv
// Shared state encodings and width helpers for the chained zero detector.
package chained_zero_detect_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        RESULT  = 1'b1
    } state_t;

    // Width of a word index; a single-word operand still gets a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a beat count that can hold 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/chained_zero_detect_word_flags.sv
// Per-word zero / all-ones flags, purely combinational.
module chained_zero_detect_word_flags #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] word,
    output logic             is_zero,
    output logic             is_ones
);

    assign is_zero = ~|word;
    assign is_ones = &word;

endmodule

// File: rtl/chained_zero_detect.sv
// Multi-beat zero/ones detector: accumulates flags over up to NWORDS words
// and presents one registered result per operand with output backpressure.
module chained_zero_detect
    import chained_zero_detect_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int NWORDS = 4,
    localparam int IW     = idx_w(NWORDS),
    localparam int BW     = cnt_w(NWORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             zero,
    output logic             ones,
    output logic [IW-1:0]    nz_first,
    output logic [BW-1:0]    beats
);

    state_t        state_q, state_d;
    logic          zero_acc, ones_acc, found;
    logic [IW-1:0] nz_q;
    logic [BW-1:0] cnt;
    logic          w_zero, w_ones;
    logic          accept, last_beat;

    chained_zero_detect_word_flags #(.WIDTH(WIDTH)) u_flags (
        .word    (in_data),
        .is_zero (w_zero),
        .is_ones (w_ones)
    );

    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt == BW'(NWORDS - 1)) || in_last;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            COLLECT: begin
                in_ready = !rst;
                if (accept && last_beat)
                    state_d = RESULT;
            end
            RESULT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    // Accumulators clear on the result handshake so the next operand can
    // start on the very next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= COLLECT;
            zero_acc <= 1'b1;
            ones_acc <= 1'b1;
            found    <= 1'b0;
            nz_q     <= '0;
            cnt      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                zero_acc <= zero_acc & w_zero;
                ones_acc <= ones_acc & w_ones;
                if (!w_zero && !found) begin
                    nz_q  <= IW'(cnt);
                    found <= 1'b1;
                end
                cnt <= cnt + BW'(1);
            end else if (state_q == RESULT && out_ready) begin
                zero_acc <= 1'b1;
                ones_acc <= 1'b1;
                found    <= 1'b0;
                nz_q     <= '0;
                cnt      <= '0;
            end
        end
    end

    assign zero     = zero_acc;
    assign ones     = ones_acc;
    assign nz_first = nz_q;
    assign beats    = cnt;

endmodule

// File: tb/tb_chained_zero_detect.sv
// Scoreboard bench for chained_zero_detect at WIDTH=16, NWORDS=4.
module tb_chained_zero_detect;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic        zero;
    logic        ones;
    logic [1:0]  nz_first;
    logic [2:0]  beats;

    typedef struct packed {
        logic       z;
        logic       o;
        logic [1:0] nz;
        logic [2:0] b;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_bad = 0;

    chained_zero_detect #(.WIDTH(16), .NWORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .zero      (zero),
        .ones      (ones),
        .nz_first  (nz_first),
        .beats     (beats)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic drive_word(input logic [15:0] d, input logic last);
        int k;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            if (in_ready) break;
            k++;
        end
        if (k >= 50) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Builds the expected result from the words, then streams them in.
    task automatic send_op(input logic [63:0] words, input int n, input logic use_last);
        exp_t        e;
        logic [15:0] w;
        logic        found;
        e.z = 1'b1; e.o = 1'b1; e.nz = '0; e.b = 3'(n);
        found = 1'b0;
        for (int i = 0; i < n; i++) begin
            w = words[16*i +: 16];
            if (w != 16'h0000) e.z = 1'b0;
            if (w != 16'hFFFF) e.o = 1'b0;
            if (w != 16'h0000 && !found) begin
                e.nz  = 2'(i);
                found = 1'b1;
            end
        end
        sb.push_back(e);
        for (int i = 0; i < n; i++)
            drive_word(words[16*i +: 16], use_last && (i == n - 1));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        chk("drain", sb.size(), 0);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("zero", zero, e.z);
                    chk("ones", ones, e.o);
                    chk("nz_first", nz_first, e.nz);
                    chk("beats", beats, e.b);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        rst = 1'b0;
        #1;
        chk("rst_zero", zero, 1);
        chk("rst_ones", ones, 1);
        chk("rst_beats", beats, 0);
        chk("rst_nz", nz_first, 0);
        chk("idle_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // All-zero operand with latency check, then back-to-back operands.
        send_op(64'h0000_0000_0000_0000, 4, 1'b0);
        @(negedge clk);
        chk("latency_out_valid", out_valid, 1);
        @(posedge clk); #1;
        send_op(64'h0001_8000_0000_0000, 4, 1'b0);
        send_op(64'hFFFF_FFFF_FFFF_FFFF, 4, 1'b0);
        send_op(64'hFFFF_FFFF_FFFE_FFFF, 4, 1'b0);
        send_op(64'h0000_0000_0000_0000, 2, 1'b1);
        send_op(64'h0010_0000_0000_0000, 4, 1'b0);
        send_op(64'h0000_0000_0000_00A5, 1, 1'b1);
        drain();

        // Backpressure: result held while stray input is offered.
        out_ready = 1'b0;
        send_op(64'h0000_0000_00FF_0000, 4, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_beats", beats, 4);
            chk("bp_nz", nz_first, 1);
            chk("bp_zero", zero, 0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_beats", beats, 0);
        chk("bp_release_out_valid", out_valid, 0);
        chk("bp_sb_empty", sb.size(), 0);

        // Reset mid-operand discards the partial words.
        drive_word(16'h0000, 1'b0);
        drive_word(16'h0000, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_beats", beats, 0);
        chk("mid_rst_zero", zero, 1);
        send_op(64'h0000_0000_0000_0001, 4, 1'b0);
        drain();

        chk("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
